// File: rtl/instr_encode_writer_if.sv
// Descriptor-in / IMEM-write-out handshake bundle for the RV32I encoder.
// master = descriptor source and IMEM sink; slave = the encoder.
interface instr_encode_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [2:0]  in_func3;
    logic        in_func2;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_instr;

    modport master (
        output in_valid, in_kind, in_func3, in_func2, in_rd, in_rs1, in_rs2,
               in_imm, in_last, out_ready,
        input  in_ready, out_valid, out_addr, out_instr
    );

    modport slave (
        input  in_valid, in_kind, in_func3, in_func2, in_rd, in_rs1, in_rs2,
               in_imm, in_last, out_ready,
        output in_ready, out_valid, out_addr, out_instr
    );
endinterface

// File: rtl/instr_encode_writer.sv
// Sequential RV32I encoder: turns compact op descriptors into 32-bit words
// and streams them to IMEM at BASE_ADDR + 4*index through one register stage.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting and encoding descriptors
// DONE  | program finished (in_last seen or window full); start restarts
module instr_encode_writer #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instr_encode_writer_if.slave  bus,
    output logic                  done,
    output logic                  err_illegal,
    output logic                  err_align,
    output logic                  err_full
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_addr_q, out_addr_d;
    logic [31:0]         out_instr_q, out_instr_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_align_q, err_align_d;
    logic                err_full_q, err_full_d;

    logic        accept;
    logic [31:0] enc;
    logic        illegal;
    logic        misalign;
    logic [2:0]  f3;
    logic [31:0] imm;

    assign f3  = bus.in_func3;
    assign imm = bus.in_imm;

    assign bus.in_ready  = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_instr = out_instr_q;
    assign done          = (state_q == DONE);
    assign err_illegal   = err_illegal_q;
    assign err_align     = err_align_q;
    assign err_full      = err_full_q;

    // Encode the presented descriptor; illegal ones collapse to a NOP.
    always_comb begin
        enc      = NOP;
        illegal  = 1'b0;
        misalign = 1'b0;
        case (bus.in_kind)
            4'd0: begin
                illegal = bus.in_func2 && (f3 != 3'b000) && (f3 != 3'b101);
                enc = {1'b0, bus.in_func2, 5'b0, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011};
            end
            4'd1: begin
                illegal = bus.in_func2 && (f3 != 3'b101);
                if (f3 == 3'b001 || f3 == 3'b101)
                    enc = {1'b0, bus.in_func2, 5'b0, imm[4:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011};
                else
                    enc = {imm[11:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011};
            end
            4'd2: begin
                illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                enc = {imm[11:0], bus.in_rs1, f3, bus.in_rd, 7'b0000011};
            end
            4'd3: begin
                illegal = (f3 > 3'b010);
                enc = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], 7'b0100011};
            end
            4'd4: begin
                illegal  = (f3 == 3'b010) || (f3 == 3'b011);
                misalign = imm[0];
                enc = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3, imm[4:1], imm[11], 7'b1100011};
            end
            4'd5: enc = {imm[31:12], bus.in_rd, 7'b0010111};
            4'd6: enc = {imm[31:12], bus.in_rd, 7'b0110111};
            4'd7: begin
                misalign = imm[0];
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
            end
            4'd8: enc = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b1100111};
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            enc      = NOP;
            misalign = 1'b0;
        end
    end

    // Next-state, word index, output stage and sticky error flags.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        out_valid_d   = out_valid_q;
        out_addr_d    = out_addr_q;
        out_instr_d   = out_instr_q;
        err_illegal_d = err_illegal_q;
        err_align_d   = err_align_q;
        err_full_d    = err_full_q;

        if (bus.out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = RUN;
                    idx_d         = '0;
                    err_illegal_d = 1'b0;
                    err_align_d   = 1'b0;
                    err_full_d    = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    out_valid_d   = 1'b1;
                    out_addr_d    = BASE_ADDR + {{(30-ADDR_W){1'b0}}, idx_q, 2'b00};
                    out_instr_d   = enc;
                    idx_d         = idx_q + ADDR_W'(1);
                    err_illegal_d = err_illegal_q | illegal;
                    err_align_d   = err_align_q | misalign;
                    if (bus.in_last) begin
                        state_d = DONE;
                    end else if (&idx_q) begin
                        err_full_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            out_valid_q   <= 1'b0;
            out_addr_q    <= BASE_ADDR;
            out_instr_q   <= 32'h0;
            err_illegal_q <= 1'b0;
            err_align_q   <= 1'b0;
            err_full_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_instr_q   <= out_instr_d;
            err_illegal_q <= err_illegal_d;
            err_align_q   <= err_align_d;
            err_full_q    <= err_full_d;
        end
    end
endmodule

// File: tb/tb_instr_encode_writer.sv
// Scoreboard bench for instr_encode_writer: expected words are queued when a
// descriptor is accepted and popped when the IMEM write handshake happens.
module tb_instr_encode_writer;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, done, err_illegal, err_align, err_full;
    logic start2, done2, err_illegal2, err_align2, err_full2;

    instr_encode_writer_if bus();
    instr_encode_writer_if bus2();

    instr_encode_writer #(.ADDR_W(12), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .done(done), .err_illegal(err_illegal), .err_align(err_align), .err_full(err_full)
    );

    instr_encode_writer #(.ADDR_W(2), .BASE_ADDR(BASE)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
        .done(done2), .err_illegal(err_illegal2), .err_align(err_align2), .err_full(err_full2)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   exp_idx = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop and compare on every IMEM write handshake of the main instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra_word", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_addr", bus.out_addr, e.addr);
                chk("sb_instr", bus.out_instr, e.instr);
            end
        end
    end

    task automatic drive(input logic [3:0] kind, input logic [2:0] f3, input logic f2,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic last);
        bus.in_kind  = kind;
        bus.in_func3 = f3;
        bus.in_func2 = f2;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        bus.in_last  = last;
    endtask

    task automatic send(input string tag, input logic [3:0] kind, input logic [2:0] f3,
                        input logic f2, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_instr);
        bit accepted = 0;
        drive(kind, f3, f2, rd, rs1, rs2, imm, last);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            sb.push_back('{BASE + 32'(exp_idx * 4), exp_instr});
            exp_idx++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_idx = 0;
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_drain_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b1;
        bus2.in_kind = 4'd1; bus2.in_func3 = 3'd0; bus2.in_func2 = 1'b0;
        bus2.in_rd = 5'd1; bus2.in_rs1 = 5'd0; bus2.in_rs2 = 5'd0;
        bus2.in_imm = 32'd0; bus2.in_last = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_illegal, err_align, err_full}, 0);
        chk("rst_out_addr", bus.out_addr, BASE);
        chk("rst_out_instr", bus.out_instr, 0);

        // Basic stream and format coverage, out_ready held high.
        pulse_start();
        send("add",  4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3);
        send("sub",  4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h402081B3);
        send("addi", 4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093);
        send("lw",   4'd2, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8, 1'b0, 32'h00812283);
        send("sw",   4'd3, 3'b010, 1'b0, 5'd0, 5'd2, 5'd5, 32'd12, 1'b0, 32'h00512623);
        send("beq",  4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3);
        send("jal",  4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 32'h008000EF);
        send("lui",  4'd6, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h123452B7);
        send("srai", 4'd1, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0, 32'h40315093);

        // Back-pressure: srai (index 8) must sit on out_* while the next waits.
        bus.out_ready = 1'b0;
        drive(4'd5, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0000_1000, 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_addr", bus.out_addr, BASE + 32'h20);
            chk("stall_out_instr", bus.out_instr, 32'h40315093);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send("auipc", 4'd5, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0000_1000, 1'b0, 32'h00001397);
        send("jalr",  4'd8, 3'b111, 1'b0, 5'd1, 5'd5, 5'd0, 32'd16, 1'b0, 32'h010280E7);

        // Illegal / misaligned descriptors and sticky flags.
        send("kind10", 4'd10, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, NOP);
        chk("err_illegal_set", err_illegal, 1);
        chk("err_align_clear", err_align, 0);
        send("br_f3_010", 4'd4, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, NOP);
        send("beq_odd", 4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 1'b1, 32'h00208263);
        chk("err_align_set", err_align, 1);
        chk("done_after_last", done, 1);
        chk("err_full_clear", err_full, 0);
        wait_drain("illegal");
        repeat (3) @(posedge clk);
        #1;
        chk("flags_sticky", {err_illegal, err_align}, 2'b11);
        chk("done_sticky", done, 1);
        pulse_start();
        chk("flags_cleared", {err_illegal, err_align, err_full}, 0);
        chk("done_cleared", done, 0);
        send("add_restart", 4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        wait_drain("restart");

        // Reset while a word is pending.
        pulse_start();
        bus.out_ready = 1'b0;
        send("addi_drop", 4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093);
        chk("pending_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_addr", bus.out_addr, BASE);
        chk("mid_rst_out_instr", bus.out_instr, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_errs_done", {done, err_illegal, err_align, err_full}, 0);
        sb.delete();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        pulse_start();
        send("lui_after_rst", 4'd6, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h123452B7);
        wait_drain("after_rst");

        // Window-full on the 4-word instance.
        @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit acc = 0;
            bus2.in_imm = 32'(i);
            bus2.in_valid = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bus2.in_ready) begin
                    acc = 1;
                    break;
                end
            end
            if (!acc) chk("full_accept_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1 bus2.in_valid = 1'b0;
            chk("full_addr", bus2.out_addr, BASE + 32'(i * 4));
            chk("full_instr", bus2.out_instr, (32'(i) << 20) | 32'h93);
            if (i < 3) chk("full_done_early", {done2, err_full2}, 0);
        end
        chk("full_done", done2, 1);
        chk("full_err_full", err_full2, 1);
        chk("full_in_ready", bus2.in_ready, 0);

        chk("sb_leftover", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
